// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared widths and FSM state encoding for multi_operand_accum
package accum_pkg;

  localparam int OPW  = 4;
  localparam int SUMW = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD_B = 3'd1,
    ADD_C = 3'd2,
    ADD_D = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [SUMW-1:0] zext(input logic [OPW-1:0] v);
    return {{(SUMW-OPW){1'b0}}, v};
  endfunction

endpackage

// File: rtl/ripple_add6.sv
// rtl/ripple_add6.sv - 6-bit ripple-carry adder, carry-in fixed at 0, no carry-out
module ripple_add6
  import accum_pkg::*;
(
  input  logic [SUMW-1:0] x,
  input  logic [SUMW-1:0] y,
  output logic [SUMW-1:0] s
);

  logic carry;

  always_comb begin
    carry = 1'b0;
    s     = '0;
    for (int i = 0; i < SUMW; i++) begin
      s[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
  end

endmodule

// File: rtl/multi_operand_accum.sv
// rtl/multi_operand_accum.sv - sequential a+b+c+d accumulator, one shared adder
// Optional avg output (sum>>2) enabled by macro MULTI_OPERAND_ACCUM_AVG_EN.
module multi_operand_accum
  import accum_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic [OPW-1:0]  c,
  input  logic [OPW-1:0]  d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SUMW-1:0] sum
`ifdef MULTI_OPERAND_ACCUM_AVG_EN
  ,
  output logic [OPW-1:0]  avg
`endif
);

  state_t          state, state_nxt;
  logic [SUMW-1:0] acc;
  logic [OPW-1:0]  b_q, c_q, d_q;
  logic [OPW-1:0]  opnd;
  logic [SUMW-1:0] add_s;
  logic            accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ADD_B;
      end
      ADD_B: state_nxt = ADD_C;
      ADD_C: state_nxt = ADD_D;
      ADD_D: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Operand fed to the single adder is chosen by which add step we are in.
  always_comb begin
    opnd = d_q;
    case (state)
      ADD_B:   opnd = b_q;
      ADD_C:   opnd = c_q;
      default: opnd = d_q;
    endcase
  end

  ripple_add6 u_add (
    .x (acc),
    .y (zext(opnd)),
    .s (add_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
    end else if (accept) begin
      acc <= zext(a);
      b_q <= b;
      c_q <= c;
      d_q <= d;
    end else if (state == ADD_B || state == ADD_C || state == ADD_D) begin
      acc <= add_s;
    end
  end

  assign sum = acc;

`ifdef MULTI_OPERAND_ACCUM_AVG_EN
  assign avg = acc[SUMW-1:SUMW-OPW];
`endif

endmodule

// File: tb/tb_multi_operand_accum.sv
// tb/tb_multi_operand_accum.sv - directed and random checks of multi_operand_accum against a plain-arithmetic model
module tb_multi_operand_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a, b, c, d;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] sum;
`ifdef MULTI_OPERAND_ACCUM_AVG_EN
  logic [3:0] avg;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_operand_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
`ifdef MULTI_OPERAND_ACCUM_AVG_EN
    ,
    .avg       (avg)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_avg(input string tag, input int exp_sum);
`ifdef MULTI_OPERAND_ACCUM_AVG_EN
    chk(tag, 32'(avg), 32'(exp_sum / 4));
`endif
  endtask

  // One full transaction: accept, scramble inputs while busy, wait for result,
  // optionally hold backpressure, then release.
  task automatic do_op(input string tag, input logic [3:0] va, vb, vc, vd, input int hold);
    int exp_sum;
    int edges;
    logic [5:0] held;
    exp_sum = int'(va) + int'(vb) + int'(vc) + int'(vd);
    @(negedge clk);
    a = va; b = vb; c = vc; d = vd;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    a = 4'hF; b = 4'hF; c = 4'hF; d = 4'hF;
    edges = 0;
    while (!out_valid && edges < 20) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      edges++;
      a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
    end
    out_ready = 1'b0;
    chk({tag, "_lat"}, 32'(edges), 32'd3);
    chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    chk_avg({tag, "_avg"}, exp_sum);
    held = sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      @(negedge clk);
      chk({tag, "_hold_sum"}, 32'(sum), 32'(held));
      chk({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rel_vld"}, 32'(out_valid), 32'd0);
    chk({tag, "_rel_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int q[$];
    int sent, got, cyc, last_cyc;
    logic [3:0] ra, rb, rc, rd;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    #1;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk_avg("rst_avg", 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while in ADD_C, then a fresh 1+1+1+1
    @(negedge clk);
    a = 4'd2; b = 4'd2; c = 4'd2; d = 4'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vld", 32'(out_valid), 32'd0);
    chk("midrst_rdy", 32'(in_ready), 32'd1);
    chk("midrst_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("ones", 4'd1, 4'd1, 4'd1, 4'd1, 0);

    do_op("max",   4'd15, 4'd15, 4'd15, 4'd15, 0);
    do_op("zero",  4'd0,  4'd0,  4'd0,  4'd0,  0);
    do_op("bp",    4'd3,  4'd5,  4'd7,  4'd9,  10);
    do_op("chg",   4'd1,  4'd2,  4'd3,  4'd4,  0);
    for (int k = 0; k < 6; k++) begin
      ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom); rd = 4'($urandom);
      do_op("rnd", ra, rb, rc, rd, int'($urandom_range(0, 3)));
    end

    // Back-to-back streaming with in_valid and out_ready held high
    sent = 0; got = 0; cyc = 0; last_cyc = -1;
    out_ready = 1'b1;
    while ((sent < 8 || got < 8) && cyc < 200) begin
      if (out_valid) begin
        if (q.size() > 0) begin
          chk("stream_sum", 32'(sum), 32'(q[0]));
          void'(q.pop_front());
        end else begin
          chk("stream_extra", 32'd1, 32'd0);
        end
        if (last_cyc >= 0) chk("stream_gap", 32'(cyc - last_cyc), 32'd5);
        last_cyc = cyc;
        got++;
      end
      if (in_ready) begin
        if (sent < 8) begin
          ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom); rd = 4'($urandom);
          a = ra; b = rb; c = rc; d = rd;
          in_valid = 1'b1;
          q.push_back(int'(ra) + int'(rb) + int'(rc) + int'(rd));
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("stream_count", 32'(got), 32'd8);
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
